// File: rtl/button_pulse_gen.sv
// Debounced single-cycle press pulses for the up/down pushbuttons (bU/bD).
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses; without it a held button yields one pulse.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 15000000
) (
  input  logic clk,
  input  logic sw_on,
  input  logic raw_u,
  input  logic raw_d,
  output logic bU,
  output logic bD
);

  localparam int MAX_A = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(32'd1);
  localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + ONE_C;
    end
  endfunction

  logic [1:0] raw_s;
  logic [1:0] pulse_s;

  assign raw_s = {raw_d, raw_u};
  assign bU    = pulse_s[0];
  assign bD    = pulse_s[1];

  // Index 0 is the up channel, index 1 the down channel; nothing crosses between them.
  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic          sync1_r;
    logic          sync2_r;
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          fire_s;
    logic          pulse_r;
    logic          rep_fire_s;

    // two-flop synchronizer on the asynchronous button input
    always_ff @(posedge clk) begin
      if (!sw_on) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= raw_s[c];
        sync2_r <= sync1_r;
      end
    end

    // state, debounce count and registered pulse
    always_ff @(posedge clk) begin
      if (!sw_on) begin
        state_r <= IDLE;
        count_r <= ZERO_C;
        pulse_r <= 1'b0;
      end else begin
        state_r <= state_s;
        count_r <= count_s;
        pulse_r <= fire_s;
      end
    end

    // next state: a level is accepted only after DEBOUNCE_CYC+1 consecutive agreeing samples
    always_comb begin
      state_s = state_r;
      count_s = count_r;
      case (state_r)
        IDLE: begin
          if (sync2_r) begin
            state_s = ARM;
            count_s = ONE_C;
          end else begin
            count_s = ZERO_C;
          end
        end
        ARM: begin
          if (!sync2_r) begin
            state_s = IDLE;
            count_s = ZERO_C;
          end else if (count_r == DEB_C) begin
            state_s = HELD;
            count_s = ZERO_C;
          end else begin
            count_s = sat_inc(count_r);
          end
        end
        HELD: begin
          if (!sync2_r) begin
            state_s = REL;
            count_s = ONE_C;
          end else begin
            count_s = ZERO_C;
          end
        end
        REL: begin
          if (sync2_r) begin
            state_s = HELD;
            count_s = ZERO_C;
          end else if (count_r == DEB_C) begin
            state_s = IDLE;
            count_s = ZERO_C;
          end else begin
            count_s = sat_inc(count_r);
          end
        end
        default: begin
          state_s = IDLE;
          count_s = ZERO_C;
        end
      endcase
    end

    // output decode: press acceptance or a repeat tick
    always_comb begin
      fire_s = 1'b0;
      if ((state_r == ARM) && sync2_r && (count_r == DEB_C)) begin
        fire_s = 1'b1;
      end else if (rep_fire_s) begin
        fire_s = 1'b1;
      end else begin
        fire_s = 1'b0;
      end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD);

    logic [CW-1:0] rcnt_r;
    logic [CW-1:0] rcnt_s;
    logic          rphase_r;
    logic          rphase_s;
    logic          rep_hit_s;

    // rphase_r low: waiting out the initial delay; high: periodic repeats
    assign rep_hit_s  = rphase_r ? (rcnt_r == PER_C) : (rcnt_r == DLY_C);
    assign rep_fire_s = (state_r == HELD) && sync2_r && rep_hit_s;

    // repeat counter next value; every (re)entry into HELD restarts the delay phase
    always_comb begin
      rcnt_s   = rcnt_r;
      rphase_s = rphase_r;
      if ((state_s == HELD) && (state_r != HELD)) begin
        rcnt_s   = ONE_C;
        rphase_s = 1'b0;
      end else if (state_s == HELD) begin
        if (rep_hit_s) begin
          rcnt_s   = ONE_C;
          rphase_s = 1'b1;
        end else begin
          rcnt_s   = sat_inc(rcnt_r);
          rphase_s = rphase_r;
        end
      end else begin
        rcnt_s   = ZERO_C;
        rphase_s = 1'b0;
      end
    end

    // repeat counter register
    always_ff @(posedge clk) begin
      if (!sw_on) begin
        rcnt_r   <= ZERO_C;
        rphase_r <= 1'b0;
      end else begin
        rcnt_r   <= rcnt_s;
        rphase_r <= rphase_s;
      end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    assign pulse_s[c] = pulse_r;
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Randomized + directed bench for button_pulse_gen against a run-length behavioural model.
module tb_button_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
`ifdef AUTO_REPEAT_EN
  localparam int HOLD30_PULSES = 6;
`else
  localparam int HOLD30_PULSES = 1;
`endif

  logic clk   = 1'b0;
  logic sw_on = 1'b0;
  logic raw_u = 1'b0;
  logic raw_d = 1'b0;
  logic bU;
  logic bD;

  int n_checks = 0;
  int n_pass   = 0;

  // model: synchronizer delay line plus accepted level and length of the disagreeing run
  bit m_q1[2];
  bit m_q2[2];
  bit m_pressed[2];
  bit m_exp[2];
  int m_run[2];
  int m_held[2];

  int first_pulse[2];
  int pulse_cnt[2];

  always #5 clk = ~clk;

  button_pulse_gen #(
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .sw_on(sw_on),
    .raw_u(raw_u),
    .raw_d(raw_d),
    .bU   (bU),
    .bD   (bD)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the reference model.
  task automatic model_edge(input bit on, input bit [1:0] raw);
    for (int c = 0; c < 2; c++) begin
      bit s;
      s = m_q2[c];
      m_exp[c] = 1'b0;
      if (!on) begin
        m_q1[c] = 1'b0;
        m_q2[c] = 1'b0;
        m_pressed[c] = 1'b0;
        m_run[c] = 0;
        m_held[c] = 0;
      end else begin
        m_q2[c] = m_q1[c];
        m_q1[c] = raw[c];
        if (s != m_pressed[c]) begin
          // a level is accepted on the (DEB+1)th consecutive sample that disagrees
          if (m_run[c] == DEB) begin
            m_pressed[c] = s;
            m_run[c] = 0;
            m_held[c] = 0;
            m_exp[c] = s;
          end else begin
            m_run[c]++;
          end
        end else begin
          if (m_pressed[c]) begin
            if (m_run[c] != 0) begin
              m_held[c] = 0;
            end else begin
              m_held[c]++;
`ifdef AUTO_REPEAT_EN
              if (m_held[c] >= RD && ((m_held[c] - RD) % RP) == 0) m_exp[c] = 1'b1;
`endif
            end
          end
          m_run[c] = 0;
        end
      end
    end
  endtask

  task automatic clr_stats();
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
  endtask

  // Apply levels for n cycles, checking both outputs after every edge.
  task automatic drive(input bit u, input bit d, input bit on, input int n);
    raw_u = u;
    raw_d = d;
    sw_on = on;
    first_pulse[0] = -1;
    first_pulse[1] = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge(on, {d, u});
      #1;
      check("bU", int'(bU), int'(m_exp[0]));
      check("bD", int'(bD), int'(m_exp[1]));
      if (bU) begin
        if (first_pulse[0] < 0) first_pulse[0] = i;
        pulse_cnt[0]++;
      end
      if (bD) begin
        if (first_pulse[1] < 0) first_pulse[1] = i;
        pulse_cnt[1]++;
      end
    end
  endtask

  initial begin
    clr_stats();
    drive(1'b0, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b1, 3);
    check("reset_quiet", pulse_cnt[0] + pulse_cnt[1], 0);

    // clean press
    clr_stats();
    drive(1'b1, 1'b0, 1'b1, 9);
    check("press_latency", first_pulse[0], 6);
    check("press_count", pulse_cnt[0], 1);
    check("press_no_bD", pulse_cnt[1], 0);

    // release glitch during hold, then full release and new press
    clr_stats();
    drive(1'b0, 1'b0, 1'b1, 2);
    drive(1'b1, 1'b0, 1'b1, 8);
    check("glitch_no_pulse", pulse_cnt[0], 0);
    drive(1'b0, 1'b0, 1'b1, 10);
    drive(1'b1, 1'b0, 1'b1, 9);
    check("repress_latency", first_pulse[0], 6);
    check("repress_count", pulse_cnt[0], 1);

    // bounce on press
    drive(1'b0, 1'b0, 1'b1, 10);
    clr_stats();
    drive(1'b1, 1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b1, 9);
    check("bounce_latency", first_pulse[0], 6);
    check("bounce_count", pulse_cnt[0], 1);

    // simultaneous press
    drive(1'b0, 1'b0, 1'b1, 10);
    clr_stats();
    drive(1'b1, 1'b1, 1'b1, 9);
    check("simul_bU", first_pulse[0], 6);
    check("simul_bD", first_pulse[1], 6);

    // reset in the middle of ARM discards progress
    drive(1'b0, 1'b0, 1'b1, 10);
    clr_stats();
    drive(1'b0, 1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 1'b0, 1);
    check("rst_arm_quiet", pulse_cnt[1], 0);
    drive(1'b0, 1'b1, 1'b1, 9);
    check("rst_arm_latency", first_pulse[1], 6);
    check("rst_arm_count", pulse_cnt[1], 1);

    // long hold: repeat pulses only when the feature is built in
    drive(1'b0, 1'b0, 1'b1, 10);
    clr_stats();
    drive(1'b1, 1'b0, 1'b1, 30);
    check("hold30_first", first_pulse[0], 6);
    check("hold30_count", pulse_cnt[0], HOLD30_PULSES);

    // random segments, including occasional resets
    for (int k = 0; k < 400; k++) begin
      bit u;
      bit d;
      bit on;
      u  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      on = ($urandom_range(0, 29) != 0);
      drive(u, d, on, on ? int'($urandom_range(1, 16)) : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
